// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO, any depth >= 2, with occupancy flags,
// sticky error flags and either fall-through or registered read data.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= inc(wr_ptr);
      if (rd_acc) rd_ptr <= inc(rd_ptr);
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
      unique case (1'b1)
        wr_acc && !rd_acc: count <= count + 1'b1;
        rd_acc && !wr_acc: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  if (FWFT) begin : g_fwft
    assign out       = empty ? '0 : mem[rd_ptr];
    assign out_valid = !empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out       <= '0;
        out_valid <= 1'b0;
      end else if (clr) begin
        out       <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= rd_acc;
        if (rd_acc) out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; any integer >=2 is legal, not only powers of two.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, giving the almost-full threshold in entries (1..DEPTH).
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, giving the almost-empty threshold in entries (0..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 1, selecting the read mode: 1 = first-word-fall-through, 0 = registered read.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 clr  input  1  synchronous flush.
REQ-009 in  input  WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request.
REQ-012 out  output  WIDTH  read data.
REQ-013 out_valid  output  1  out holds valid data.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and full=0, whether or not a read occurs in the same cycle; an accepted write stores in at the write pointer.
REQ-018 A read SHALL be accepted iff rd_en=1 and empty=0; an accepted read advances the read pointer.
REQ-019 Each pointer SHALL wrap from DEPTH-1 to 0 when it advances.
REQ-020 count SHALL increment on a write-only cycle, decrement on a read-only cycle, and stay unchanged on a cycle with both or neither accepted.
REQ-021 Status flags SHALL be decoded from the registered count as follows: full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH).
REQ-022 When the FIFO is full and both wr_en and rd_en are 1, the read SHALL be accepted, the write SHALL be dropped, and overflow SHALL be set.
REQ-023 When the FIFO is empty and both wr_en and rd_en are 1, the write SHALL be accepted, the read SHALL be rejected, underflow SHALL be set, and there SHALL be no write-to-read bypass.
REQ-024 overflow SHALL be set on any cycle with wr_en=1 and full=1, and SHALL stay at 1 until reset or clr.
REQ-025 underflow SHALL be set on any cycle with rd_en=1 and empty=1, and SHALL stay at 1 until reset or clr.
REQ-026 In FWFT=1 mode, out SHALL combinationally present the head entry and out_valid SHALL equal !empty; when empty, out SHALL be 0.
REQ-027 In FWFT=1 mode, data written into an empty FIFO SHALL appear on out one cycle after the write edge.
REQ-028 In FWFT=0 mode, out SHALL be a register loaded with the head entry on each accepted read, giving read latency of 1 cycle.
REQ-029 In FWFT=0 mode, out_valid SHALL pulse high for exactly the one cycle after each accepted read, and out SHALL hold its value between reads.
REQ-030 clr=1 SHALL take priority over wr_en and rd_en and SHALL, at the next edge, zero both pointers, count, overflow, underflow, out (FWFT=0) and out_valid (FWFT=0).
REQ-031 clr SHALL NOT clear the storage array.
REQ-032 The storage array SHALL be written only on accepted writes and SHALL NOT be reset.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, set pointers=0, count=0, empty=1, full=0, almost_empty=1, overflow=0, underflow=0, out=0 and out_valid=0.
REQ-034 almost_full SHALL reset to 1 if AFULL_TH would be satisfied at count 0, and to 0 otherwise (0 for all legal thresholds).
REQ-035 Assertion of rst_n mid-transfer SHALL discard all queued entries, and the first read after release SHALL NOT return pre-reset data.
REQ-036 Writes and reads SHALL be accepted starting from the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Fill/drain (DEPTH=8, FWFT=1): write 0x01..0x08 -> full=1, count=8; then read 8 -> out sequence 0x01..0x08, then empty=1.
REQ-038 Non-power-of-two wrap (DEPTH=5): perform 12 interleaved writes and reads -> pointers wrap at 4->0, data order preserved, no spurious full/empty.
REQ-039 Simultaneous events: while full, assert wr_en and rd_en -> count goes 8->7 and overflow=1; while empty, assert both -> count goes 0->1, underflow=1, out_valid=0 that cycle.
REQ-040 Threshold flags (AFULL_TH=6, AEMPTY_TH=2): step count 0->8 -> almost_empty deasserts at 3 and almost_full asserts at 6.
REQ-041 FWFT=0 latency: write 0xA5, then pulse rd_en -> out=0xA5 with out_valid=1 exactly one cycle later, and out holds 0xA5 thereafter.
REQ-042 Reset and clr mid-operation: with count=4, pulse rst_n low between clock edges -> count=0 and empty=1 immediately; repeat with clr -> the same state at the next edge, and overflow/underflow cleared.
